wb_port_arbiter: RTL

//  Shares the single register-file write port among NUM_REQ write-back sources (e.g. ALU, load unit).

---
 rtl/wb_port_arbiter_pkg.sv | 29 ++
 rtl/wb_port_arbiter_fifo.sv | 85 ++++++++
 rtl/wb_port_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, entry type and ring helper for the write-back port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned WORD_LEN          = 32;
  localparam int unsigned REG_FILE_ADDR_LEN = 5;
  localparam int unsigned REG_FILE_SIZE     = 32;
  localparam int unsigned WB_REQ_MAX        = 4;
  localparam int unsigned WB_ID_LEN         = 2;

  typedef logic [REG_FILE_ADDR_LEN-1:0] reg_addr_t;
  typedef logic [WORD_LEN-1:0]          word_t;
  typedef logic [WB_ID_LEN-1:0]         wb_id_t;

  // One queued register-file write.
  typedef struct packed {
    reg_addr_t dest;
    word_t     val;
  } wb_entry_t;

  // (base + inc) mod n, valid for base < n and inc < n.
  function automatic wb_id_t wrap_add(input wb_id_t base, input int unsigned inc,
                                      input int unsigned n);
    int unsigned s;
    s = 32'(base) + inc;
    if (s >= n) s = s - n;
    return wb_id_t'(s);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Per-requester synchronous FIFO; also exposes each slot's dest and
// occupancy so the top can build the pending-destination mask.
module wb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic                               pop,
  input  wb_entry_t                          din,
  output wb_entry_t                          dout,
  output logic                               full,
  output logic                               empty,
  output logic [DEPTH*REG_FILE_ADDR_LEN-1:0] ent_dest,
  output logic [DEPTH-1:0]                   ent_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  wb_entry_t mem_q [DEPTH];
  wb_entry_t mem_d [DEPTH];
  ptr_t      rd_ptr_q, rd_ptr_d;
  ptr_t      wr_ptr_q, wr_ptr_d;
  cnt_t      count_q, count_d;
  logic      do_push, do_pop;
  ptr_t      rel;

  assign full    = (count_q == cnt_t'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slot j is occupied when its distance from the read pointer is below count.
  always_comb begin
    rel       = '0;
    ent_valid = '0;
    ent_dest  = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      rel          = ptr_t'(j) - rd_ptr_q;
      ent_valid[j] = (cnt_t'(rel) < count_q);
      ent_dest[j*REG_FILE_ADDR_LEN +: REG_FILE_ADDR_LEN] = mem_q[j].dest;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ
// write-back sources, each buffered by a private FIFO.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*REG_FILE_ADDR_LEN-1:0]  req_dest,
  input  logic [NUM_REQ*WORD_LEN-1:0]           req_val,
  output logic                                  writeEn,
  output logic [REG_FILE_ADDR_LEN-1:0]          dest,
  output logic [WORD_LEN-1:0]                   writeVal,
  output logic [REG_FILE_SIZE-1:0]              pending,
  output logic [WB_ID_LEN-1:0]                  grant_id
);

  wb_entry_t                                  fifo_din  [NUM_REQ];
  wb_entry_t                                  fifo_dout [NUM_REQ];
  logic [NUM_REQ-1:0]                         fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FIFO_DEPTH*REG_FILE_ADDR_LEN-1:0]    ent_dest  [NUM_REQ];
  logic [FIFO_DEPTH-1:0]                      ent_valid [NUM_REQ];

  wb_id_t                  rr_q, rr_d;
  logic                    we_q, we_d;
  reg_addr_t               dest_q, dest_d;
  word_t                   val_q, val_d;
  wb_id_t                  gid_q, gid_d;

  logic                    pick_found;
  wb_id_t                  pick_id, cand;
  logic [WB_REQ_MAX-1:0]   nonempty_pad;
  wb_entry_t               dout_pad [WB_REQ_MAX];
  wb_entry_t               sel_entry;
  logic [REG_FILE_SIZE-1:0] pend;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign fifo_din[i]  = '{dest: req_dest[i*REG_FILE_ADDR_LEN +: REG_FILE_ADDR_LEN],
                            val:  req_val[i*WORD_LEN +: WORD_LEN]};
    assign fifo_push[i] = req_valid[i] && !fifo_full[i];
    assign fifo_pop[i]  = pick_found && (pick_id == wb_id_t'(i));

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push[i]),
      .pop       (fifo_pop[i]),
      .din       (fifo_din[i]),
      .dout      (fifo_dout[i]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i]),
      .ent_dest  (ent_dest[i]),
      .ent_valid (ent_valid[i])
    );
  end

  // Ready depends only on each FIFO's own occupancy, never on this cycle's pop.
  assign req_ready = ~fifo_full;

  // Round-robin pick: first non-empty FIFO at or after the rr pointer.
  always_comb begin
    nonempty_pad                = '0;
    nonempty_pad[NUM_REQ-1:0]   = ~fifo_empty;
    pick_found                  = 1'b0;
    pick_id                     = '0;
    cand                        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(rr_q, k, NUM_REQ);
      if (!pick_found && nonempty_pad[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Head-of-queue mux for the winning requester.
  always_comb begin
    dout_pad = '{default: '0};
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      dout_pad[k] = fifo_dout[k];
    end
    sel_entry = dout_pad[pick_id];
  end

  // Output stage and rr pointer next-state; dest 0 is consumed without a write.
  always_comb begin
    we_d   = 1'b0;
    dest_d = dest_q;
    val_d  = val_q;
    gid_d  = gid_q;
    rr_d   = rr_q;
    if (pick_found) begin
      we_d   = (sel_entry.dest != '0);
      dest_d = sel_entry.dest;
      val_d  = sel_entry.val;
      gid_d  = pick_id;
      rr_d   = wrap_add(pick_id, 1, NUM_REQ);
    end
  end

  // Output register and rr pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      dest_q <= '0;
      val_q  <= '0;
      gid_q  <= '0;
      rr_q   <= '0;
    end else begin
      we_q   <= we_d;
      dest_q <= dest_d;
      val_q  <= val_d;
      gid_q  <= gid_d;
      rr_q   <= rr_d;
    end
  end

  // Pending mask: every queued dest plus the live output-stage dest; r0 never pends.
  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
        if (ent_valid[i][j]) begin
          pend[ent_dest[i][j*REG_FILE_ADDR_LEN +: REG_FILE_ADDR_LEN]] = 1'b1;
        end
      end
    end
    if (we_q) pend[dest_q] = 1'b1;
    pend[0] = 1'b0;
  end

  assign writeEn  = we_q;
  assign dest     = dest_q;
  assign writeVal = val_q;
  assign grant_id = gid_q;
  assign pending  = pend;

endmodule
